// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types and helpers for the shared memory port
//
// Purpose: port count, FSM state encoding and the one-hot bit select used by
//          the owner-driven field multiplexers.
// Ports:   none (package).

package shared_mem_pkg;

  // Requester count; fixed to 4 to line up with the round-robin arbiter.
  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // One-hot select of a single bit column: bits[i] is port i's copy of the
  // bit. A zero select yields 0, which keeps the latched fields clean.
  function automatic logic onehot_sel(input logic [N_PORTS-1:0] sel,
                                      input logic [N_PORTS-1:0] bits);
    return |(sel & bits);
  endfunction

endpackage

// File: rtl/shared_mem_port_onehot_mux.sv
// rtl/shared_mem_port_onehot_mux.sv - AND-OR field select by one-hot owner
//
// Purpose: picks port i's W-bit field out of a packed per-port vector when
//          sel is one-hot at bit i; returns 0 when sel is zero.
// Ports:   sel  in  N_PORTS    one-hot (or zero) port select
//          vec  in  N_PORTS*W  per-port fields, port i at [i*W +: W]
//          y    out W          selected field

module shared_mem_port_onehot_mux
  import shared_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [N_PORTS-1:0]   sel,
  input  logic [N_PORTS*W-1:0] vec,
  output logic [W-1:0]         y
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    // Gather bit b of every port into one column, then select by owner.
    logic [N_PORTS-1:0] col;
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign col[i] = vec[i*W + b];
    end
    assign y[b] = onehot_sel(sel, col);
  end

endmodule

// File: rtl/shared_mem_port.sv
// rtl/shared_mem_port.sv - single shared memory port behind a 4-way arbiter
//
// Purpose: forwards per-port requests to the arbiter, accepts the port whose
//          registered grant lines up with a live request, runs that one
//          command on the shared memory port and routes the response back.
// Ports:   clk, rst                     clock, synchronous active-high reset
//          cpu_req_valid/ready/we       per-port request handshake and type
//          cpu_req_addr/wdata           per-port packed address / write data
//          cpu_rsp_valid, cpu_rsp_rdata one-cycle response strobe + data
//          arb_req, arb_gnt             arbiter request out, registered grant in
//          mem_valid/ready/we/addr/wdata shared memory command channel
//          mem_rsp_valid, mem_rdata     shared memory response channel
//          err_stray_rsp                sticky: response seen outside WAIT_RSP

module shared_mem_port
  import shared_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          cpu_req_valid,
  output logic [N_PORTS-1:0]          cpu_req_ready,
  input  logic [N_PORTS-1:0]          cpu_req_we,
  input  logic [N_PORTS*ADDR_W-1:0]   cpu_req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   cpu_req_wdata,
  output logic [N_PORTS-1:0]          cpu_rsp_valid,
  output logic [DATA_W-1:0]           cpu_rsp_rdata,
  output logic [N_PORTS-1:0]          arb_req,
  input  logic [N_PORTS-1:0]          arb_gnt,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        err_stray_rsp
);

  state_t              state;
  state_t              state_nx;
  logic [N_PORTS-1:0]  owner;
  logic [N_PORTS-1:0]  hit;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A grant only counts if the port is still asking; a grant for a dropped
  // request falls out here and the FSM stays in IDLE.
  assign hit = arb_gnt & cpu_req_valid;

  shared_mem_port_onehot_mux #(.W(1)) u_mux_we (
    .sel (hit),
    .vec (cpu_req_we),
    .y   (sel_we)
  );

  shared_mem_port_onehot_mux #(.W(ADDR_W)) u_mux_addr (
    .sel (hit),
    .vec (cpu_req_addr),
    .y   (sel_addr)
  );

  shared_mem_port_onehot_mux #(.W(DATA_W)) u_mux_wdata (
    .sel (hit),
    .vec (cpu_req_wdata),
    .y   (sel_wdata)
  );

  always_comb begin
    state_nx      = state;
    arb_req       = '0;
    cpu_req_ready = '0;
    mem_valid     = 1'b0;
    case (state)
      IDLE: begin
        arb_req       = cpu_req_valid;
        cpu_req_ready = hit;
        if (|hit) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // Requests are withheld from the arbiter while busy; the grant it
        // registered from the last IDLE cycle arrives now and is ignored.
        mem_valid = 1'b1;
        if (mem_ready) begin
          state_nx = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // Keep every output quiet while reset is held, even the combinational ones.
    if (rst) begin
      arb_req       = '0;
      cpu_req_ready = '0;
      mem_valid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      cpu_rsp_valid <= '0;
      cpu_rsp_rdata <= '0;
      err_stray_rsp <= 1'b0;
    end else begin
      state         <= state_nx;
      cpu_rsp_valid <= '0;
      if (state == IDLE && |hit) begin
        owner     <= hit;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (state == WAIT_RSP && mem_rsp_valid) begin
        cpu_rsp_valid <= owner;
        // Write acks carry no data; never leak whatever is on mem_rdata.
        cpu_rsp_rdata <= lat_we ? '0 : mem_rdata;
      end
      if (state != WAIT_RSP && mem_rsp_valid) begin
        err_stray_rsp <= 1'b1;
      end
    end
  end

  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

endmodule
